// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package fetch_unit_pkg;

  // Fetch FSM encodings; control decodes the same opcode constants.
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;

  // Word-offset branch displacement: sign-extend the 16-bit immediate, scale by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump > taken branch > sequential.
// Kept separate so a pipelined front end can reuse it.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic [31:0]       instruction,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] jmp_pc;
  logic              unused_opcode;

  assign seq_pc        = inst_pc + ADDR_W'(4);
  assign br_pc         = seq_pc + ADDR_W'(branch_offset(instruction[15:0]));
  assign unused_opcode = ^instruction[31:26];

  // Upper PC bits only survive a jump when the address space exceeds 28 bits.
  if (ADDR_W > 28) begin : g_wide_jump
    assign jmp_pc = {seq_pc[ADDR_W-1:28], instruction[25:0], 2'b00};
  end else begin : g_narrow_jump
    assign jmp_pc = ADDR_W'({instruction[25:0], 2'b00});
  end

  // Priority select of the next fetch address.
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = jmp_pc;
    end else if (branch && alu_zero) begin
      next_pc = br_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds each word until decode takes it, then advances the PC.
//
// state    | meaning
// FS_IDLE  | post-reset bubble, no request outstanding
// FS_FETCH | imem_req asserted at pc, waiting for imem_ack
// FS_HOLD  | instruction held valid, waiting for inst_ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic              jump
);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .inst_pc     (inst_pc),
    .instruction (instruction),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .jump        (jump),
    .next_pc     (next_pc)
  );

  assign imem_addr = pc;

  // State register; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      FS_IDLE: begin
        state_next = FS_FETCH;
      end
      FS_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = FS_HOLD;
        end
      end
      FS_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          state_next = FS_FETCH;
        end
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  // PC and holding registers; acks and readies are only honoured in their own state.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc          <= RESET_PC;
      instruction <= 32'h0;
      inst_pc     <= RESET_PC;
    end else if (state == FS_FETCH && imem_ack) begin
      instruction <= imem_rdata;
      inst_pc     <= pc;
    end else if (state == FS_HOLD && inst_ready) begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit with a transaction-level PC model.
module tb_fetch_unit;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = 32'h0;
  logic              inst_ready = 1'b0;
  logic              branch = 1'b0;
  logic              alu_zero = 1'b0;
  logic              jump = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              inst_valid;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] inst_pc;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_pc   = 0;
  int t_prev   = 0;
  int t_valid  = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .clr         (clr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .jump        (jump)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Next fetch address from the architectural rules, modulo 2^8.
  function automatic int model_next(input int pc, input logic [31:0] word,
                                    input logic br, input logic z, input logic jp);
    int imm;
    imm = int'($signed(word[15:0]));
    if (jp) return (int'(word[25:0]) * 4) % 256;
    if (br && z) return (((pc + 4 + imm * 4) % 256) + 256) % 256;
    return (pc + 4) % 256;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs that must be ignored in the current state get random values.
  task automatic rand_ctrl();
    inst_ready = 1'($urandom_range(0, 1));
    branch     = 1'($urandom_range(0, 1));
    alu_zero   = 1'($urandom_range(0, 1));
    jump       = 1'($urandom_range(0, 1));
  endtask

  // One full fetch transaction: w request cycles before the ack, h stall cycles in hold.
  task automatic do_fetch(input logic [31:0] word, input int w, input int h,
                          input logic br, input logic z, input logic jp);
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(exp_pc));
    for (int i = 0; i < w; i++) begin
      imem_ack = 1'b0;
      rand_ctrl();
      step();
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", 32'(imem_addr), 32'(exp_pc));
      check("valid_in_fetch", 32'(inst_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    rand_ctrl();
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    t_prev     = t_valid;
    t_valid    = cyc;
    check("valid_after_ack", 32'(inst_valid), 32'd1);
    check("instr_capture", instruction, word);
    check("inst_pc_capture", 32'(inst_pc), 32'(exp_pc));
    check("no_req_in_hold", 32'(imem_req), 32'd0);
    for (int i = 0; i < h; i++) begin
      rand_ctrl();
      inst_ready = 1'b0;
      step();
      check("valid_stall", 32'(inst_valid), 32'd1);
      check("instr_stall", instruction, word);
      check("inst_pc_stall", 32'(inst_pc), 32'(exp_pc));
      check("no_req_stall", 32'(imem_req), 32'd0);
    end
    inst_ready = 1'b1;
    branch     = br;
    alu_zero   = z;
    jump       = jp;
    exp_pc     = model_next(exp_pc, word, br, z, jp);
    step();
    rand_ctrl();
    check("req_after_ready", 32'(imem_req), 32'd1);
    check("next_addr", 32'(imem_addr), 32'(exp_pc));
    check("valid_drop", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    // Reset, with a stray ack during reset that must not be captured.
    clr = 1'b1;
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hA5A5_5A5A;
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_inst_pc", 32'(inst_pc), 32'(RESET_PC));
    check("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    clr      = 1'b0;
    imem_ack = 1'b0;
    step();
    check("first_req", 32'(imem_req), 32'd1);
    exp_pc = int'(RESET_PC);

    // Zero-wait (registered) memory returning NOPs, ready immediately.
    do_fetch(32'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    check("valid_period", 32'(t_valid - t_prev), 32'd3);

    // Slow ack at 0x08 and a 5-cycle downstream stall.
    do_fetch(32'h0000_0000, 4, 5, 1'b0, 1'b0, 1'b0);

    // 0x0C: jump to 0x10; beq back to 0x04 when taken.
    do_fetch({6'h02, 26'h4}, 1, 0, 1'b0, 1'b0, 1'b1);
    do_fetch({6'h04, 5'd1, 5'd2, 16'hFFFC}, 1, 0, 1'b1, 1'b1, 1'b0);
    check("beq_taken", 32'(exp_pc), 32'h04);
    // 0x04: jump to 0x10; beq not taken goes to 0x14.
    do_fetch({6'h02, 26'h4}, 2, 1, 1'b0, 1'b0, 1'b1);
    do_fetch({6'h04, 5'd1, 5'd2, 16'hFFFC}, 1, 0, 1'b1, 1'b0, 1'b0);
    // 0x14: jump to 0x20; jump + branch together, jump wins -> 0x40.
    do_fetch({6'h02, 26'h8}, 1, 0, 1'b0, 1'b0, 1'b1);
    do_fetch({6'h02, 26'h10}, 1, 0, 1'b1, 1'b1, 1'b1);
    check("jump_priority", 32'(exp_pc), 32'h40);

    // Wrap-around: jump to 0xFC, sequential fetch wraps to 0x00.
    do_fetch({6'h02, 26'h3F}, 1, 0, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    check("wrap", 32'(exp_pc), 32'h00);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      do_fetch($urandom, $urandom_range(1, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
    end

    // clr in FETCH together with an ack, then a stale ack while idle.
    clr        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    step();
    check("clr_req", 32'(imem_req), 32'd0);
    check("clr_valid", 32'(inst_valid), 32'd0);
    check("clr_instr", instruction, 32'h0);
    check("clr_inst_pc", 32'(inst_pc), 32'(RESET_PC));
    imem_ack = 1'b0;
    step();
    clr      = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("stale_ack_req", 32'(imem_req), 32'd1);
    check("stale_ack_valid", 32'(inst_valid), 32'd0);
    check("restart_addr", 32'(imem_addr), 32'(RESET_PC));
    exp_pc = int'(RESET_PC);
    do_fetch(32'h1234_5678, 2, 1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
